// File: rtl/pulse_train_generator.sv
// Pulse train generator: on a start request emits num_pulses pulses on a
// registered line, each high_len cycles high separated by max(low_len,1)
// cycles low. Reports busy during the train and a done strobe at the end.
module pulse_train_generator #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [CNT_W-1:0] i_high_len,
   input  logic [CNT_W-1:0] i_low_len,
   input  logic [CNT_W-1:0] i_num_pulses,
   output logic             o_out,
   output logic             o_pulse_start,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // Phase counter holds remaining cycles of the current phase minus one.
   logic [CNT_W-1:0] r_phase_cnt;
   logic [CNT_W-1:0] w_phase_cnt_nxt;
   // Pulses still to be emitted after the one currently in progress.
   logic [CNT_W-1:0] r_pulses_left;
   logic [CNT_W-1:0] w_pulses_left_nxt;
   // Latched phase reload values (already reduced by one).
   logic [CNT_W-1:0] r_high_rld;
   logic [CNT_W-1:0] w_high_rld_nxt;
   logic [CNT_W-1:0] r_low_rld;
   logic [CNT_W-1:0] w_low_rld_nxt;

   logic             r_out;
   logic             r_pulse_start;
   logic             r_busy;
   logic             r_done;
   logic             w_out_nxt;
   logic             w_pulse_start_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   // Next-state, counter and registered-output decode
   always_comb begin
      w_state_nxt       = r_state;
      w_phase_cnt_nxt   = r_phase_cnt;
      w_pulses_left_nxt = r_pulses_left;
      w_high_rld_nxt    = r_high_rld;
      w_low_rld_nxt     = r_low_rld;
      w_out_nxt         = 1'b0;
      w_pulse_start_nxt = 1'b0;
      w_busy_nxt        = 1'b0;
      w_done_nxt        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_start && !i_abort) begin
               if ((i_num_pulses == CNT_ZERO) || (i_high_len == CNT_ZERO)) begin
                  // Empty train: finish immediately without emitting a pulse.
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt       = ST_HIGH;
                  w_high_rld_nxt    = i_high_len - CNT_ONE;
                  w_low_rld_nxt     = (i_low_len == CNT_ZERO) ? CNT_ZERO
                                                              : i_low_len - CNT_ONE;
                  w_phase_cnt_nxt   = i_high_len - CNT_ONE;
                  w_pulses_left_nxt = i_num_pulses - CNT_ONE;
                  w_out_nxt         = 1'b1;
                  w_pulse_start_nxt = 1'b1;
                  w_busy_nxt        = 1'b1;
               end
            end
         end

         ST_HIGH: begin
            if (i_abort) begin
               w_state_nxt       = ST_IDLE;
               w_phase_cnt_nxt   = CNT_ZERO;
               w_pulses_left_nxt = CNT_ZERO;
            end else if (r_phase_cnt != CNT_ZERO) begin
               w_phase_cnt_nxt = r_phase_cnt - CNT_ONE;
               w_out_nxt       = 1'b1;
               w_busy_nxt      = 1'b1;
            end else if (r_pulses_left != CNT_ZERO) begin
               w_state_nxt     = ST_LOW;
               w_phase_cnt_nxt = r_low_rld;
               w_busy_nxt      = 1'b1;
            end else begin
               // Last pulse finished: no trailing gap.
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end

         ST_LOW: begin
            if (i_abort) begin
               w_state_nxt       = ST_IDLE;
               w_phase_cnt_nxt   = CNT_ZERO;
               w_pulses_left_nxt = CNT_ZERO;
            end else if (r_phase_cnt != CNT_ZERO) begin
               w_phase_cnt_nxt = r_phase_cnt - CNT_ONE;
               w_busy_nxt      = 1'b1;
            end else begin
               w_state_nxt       = ST_HIGH;
               w_phase_cnt_nxt   = r_high_rld;
               w_pulses_left_nxt = r_pulses_left - CNT_ONE;
               w_out_nxt         = 1'b1;
               w_pulse_start_nxt = 1'b1;
               w_busy_nxt        = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_phase_cnt   <= CNT_ZERO;
         r_pulses_left <= CNT_ZERO;
         r_high_rld    <= CNT_ZERO;
         r_low_rld     <= CNT_ZERO;
         r_out         <= 1'b0;
         r_pulse_start <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_phase_cnt   <= w_phase_cnt_nxt;
         r_pulses_left <= w_pulses_left_nxt;
         r_high_rld    <= w_high_rld_nxt;
         r_low_rld     <= w_low_rld_nxt;
         r_out         <= w_out_nxt;
         r_pulse_start <= w_pulse_start_nxt;
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
      end
   end

   assign o_out         = r_out;
   assign o_pulse_start = r_pulse_start;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule
